// File: rtl/intel_vvp_exposure_fusion_pkg.sv
// -----------------------------------------------------------------------------
// intel_vvp_exposure_fusion_pkg
// Shared definitions for the exposure-fusion control block: register word
// addresses, FSM state encoding (also visible in STATUS[3:2]), output-mode
// encoding and the widths of the active fusion settings.
// -----------------------------------------------------------------------------
package intel_vvp_exposure_fusion_pkg;

    localparam int MODE_W   = 2;
    localparam int BLACK_W  = 16;
    localparam int RATIO_W  = 17;
    localparam int THRESH_W = 16;
    localparam int HEIGHT_W = 16;

    localparam int ADDR_CTRL        = 0;
    localparam int ADDR_STATUS      = 1;
    localparam int ADDR_MODE        = 2;
    localparam int ADDR_BLACK       = 3;
    localparam int ADDR_RATIO       = 4;
    localparam int ADDR_THRESH      = 5;
    localparam int ADDR_HEIGHT      = 6;
    localparam int ADDR_FRAME_COUNT = 7;
    localparam int ADDR_IRQ         = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_FRAME    = 2'd2,
        ST_DRAIN    = 2'd3
    } fsm_state_e;

    typedef enum logic [1:0] {
        MODE_FUSION   = 2'd0,
        MODE_SHORT    = 2'd1,
        MODE_RESERVED = 2'd2,
        MODE_LONG     = 2'd3
    } output_mode_e;

endpackage

// File: rtl/intel_vvp_exposure_fusion_ctrl_regs.sv
// -----------------------------------------------------------------------------
// intel_vvp_exposure_fusion_ctrl_regs
// Avalon-MM register file: GO bit, shadow copies of MODE/BLACK/RATIO/THRESH,
// HEIGHT, and the registered read mux (readdatavalid one cycle after read).
// Decoded write strobes for GO-clear, COMMIT and sticky-clear go to the top.
// Optional (EXPOSURE_FUSION_CTRL_IRQ_EN): IRQ register at word 8 and irq out.
// Ports: clk/rst_n, Avalon-MM slave, status inputs (state, pending, sticky,
// frame_count), shadow/height/go outputs and write strobes.
// -----------------------------------------------------------------------------
module intel_vvp_exposure_fusion_ctrl_regs
    import intel_vvp_exposure_fusion_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write,
    input  logic                  read,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  readdatavalid,
    input  fsm_state_e            state,
    input  logic                  pending,
    input  logic                  sticky,
    input  logic [31:0]           frame_count,
    output logic                  go,
    output logic                  go_stop_wr,
    output logic                  commit_wr,
    output logic                  sticky_clr_wr,
    output logic [MODE_W-1:0]     shadow_mode,
    output logic [BLACK_W-1:0]    shadow_black,
    output logic [RATIO_W-1:0]    shadow_ratio,
    output logic [THRESH_W-1:0]   shadow_thresh,
    output logic [HEIGHT_W-1:0]   height
`ifdef EXPOSURE_FUSION_CTRL_IRQ_EN
    ,
    input  logic                  commit_pulse,
    output logic                  irq
`endif
);

    logic [31:0] addr_word;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign addr_word    = 32'(address);
    assign unused_wdata = ^writedata[31:17];

    assign go_stop_wr    = write && (addr_word == ADDR_CTRL) && !writedata[0];
    assign commit_wr     = write && (addr_word == ADDR_CTRL) && writedata[1];
    assign sticky_clr_wr = write && (addr_word == ADDR_STATUS) && writedata[4];

`ifdef EXPOSURE_FUSION_CTRL_IRQ_EN
    logic irq_enable;
    logic irq_status;

    assign irq = irq_enable & irq_status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_enable <= 1'b0;
            irq_status <= 1'b0;
        end else begin
            if (write && (addr_word == ADDR_IRQ)) irq_enable <= writedata[0];
            // A commit in the same cycle as a clear wins so no event is lost.
            if (commit_pulse) irq_status <= 1'b1;
            else if (write && (addr_word == ADDR_IRQ) && writedata[1]) irq_status <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go            <= 1'b0;
            shadow_mode   <= '0;
            shadow_black  <= '0;
            shadow_ratio  <= '0;
            shadow_thresh <= '0;
            height        <= '0;
        end else if (write) begin
            case (addr_word)
                ADDR_CTRL:   go            <= writedata[0];
                ADDR_MODE:   shadow_mode   <= writedata[MODE_W-1:0];
                ADDR_BLACK:  shadow_black  <= writedata[BLACK_W-1:0];
                ADDR_RATIO:  shadow_ratio  <= writedata[RATIO_W-1:0];
                ADDR_THRESH: shadow_thresh <= writedata[THRESH_W-1:0];
                ADDR_HEIGHT: height        <= writedata[HEIGHT_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr_word)
            ADDR_CTRL:        rd_mux = {31'd0, go};
            ADDR_STATUS:      rd_mux = {27'd0, sticky, state, pending, state != ST_IDLE};
            ADDR_MODE:        rd_mux = 32'(shadow_mode);
            ADDR_BLACK:       rd_mux = 32'(shadow_black);
            ADDR_RATIO:       rd_mux = 32'(shadow_ratio);
            ADDR_THRESH:      rd_mux = 32'(shadow_thresh);
            ADDR_HEIGHT:      rd_mux = 32'(height);
            ADDR_FRAME_COUNT: rd_mux = frame_count;
`ifdef EXPOSURE_FUSION_CTRL_IRQ_EN
            ADDR_IRQ:         rd_mux = {30'd0, irq_status, irq_enable};
`endif
            default:          rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) readdata <= rd_mux;
        end
    end

endmodule

// File: rtl/intel_vvp_exposure_fusion_ctrl.sv
// -----------------------------------------------------------------------------
// intel_vvp_exposure_fusion_ctrl
// Frame-synchronous commit controller for exposure-fusion settings. Snoops the
// fusion input stream (SOF/EOL), tracks frames against HEIGHT, waits for the
// pipeline to drain DRAIN_CYCLES tready cycles after the last line, then
// copies all shadow settings to the active outputs atomically.
// Ports: main_clock, main_reset_n (async, active-low), Avalon-MM slave
// (av_mm_*), stream snoop (snoop_*), active settings (r_vid_*).
// Optional macro EXPOSURE_FUSION_CTRL_IRQ_EN adds the irq output and the IRQ
// register at word 8.
// -----------------------------------------------------------------------------
module intel_vvp_exposure_fusion_ctrl
    import intel_vvp_exposure_fusion_pkg::*;
#(
    parameter int DRAIN_CYCLES = 13,
    parameter int ADDR_WIDTH   = 4
) (
    input  logic                  main_clock,
    input  logic                  main_reset_n,
    input  logic [ADDR_WIDTH-1:0] av_mm_address,
    input  logic                  av_mm_write,
    input  logic                  av_mm_read,
    input  logic [31:0]           av_mm_writedata,
    output logic [31:0]           av_mm_readdata,
    output logic                  av_mm_readdatavalid,
    input  logic                  snoop_tvalid,
    input  logic                  snoop_tready,
    input  logic                  snoop_tlast,
    input  logic                  snoop_tuser0,
    output logic [MODE_W-1:0]     r_vid_output_mode,
    output logic [BLACK_W-1:0]    r_vid_black_level,
    output logic [RATIO_W-1:0]    r_vid_exposure_ratio,
    output logic [THRESH_W-1:0]   r_vid_threshold
`ifdef EXPOSURE_FUSION_CTRL_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    fsm_state_e            state, state_n;
    logic [HEIGHT_W-1:0]   line_cnt, line_n, height, last_line;
    logic [DRAIN_W-1:0]    drain_cnt, drain_n;
    logic [31:0]           frame_count;
    logic                  pending, sticky, go;
    logic                  go_stop_wr, commit_wr, sticky_clr_wr;
    logic                  commit, fc_inc, early_sof;
    logic                  beat, sof, eol;
    logic [MODE_W-1:0]     shadow_mode;
    logic [BLACK_W-1:0]    shadow_black;
    logic [RATIO_W-1:0]    shadow_ratio;
    logic [THRESH_W-1:0]   shadow_thresh;
    output_mode_e          active_mode;

    intel_vvp_exposure_fusion_ctrl_regs #(.ADDR_WIDTH(ADDR_WIDTH)) u_regs (
        .clk           (main_clock),
        .rst_n         (main_reset_n),
        .address       (av_mm_address),
        .write         (av_mm_write),
        .read          (av_mm_read),
        .writedata     (av_mm_writedata),
        .readdata      (av_mm_readdata),
        .readdatavalid (av_mm_readdatavalid),
        .state         (state),
        .pending       (pending),
        .sticky        (sticky),
        .frame_count   (frame_count),
        .go            (go),
        .go_stop_wr    (go_stop_wr),
        .commit_wr     (commit_wr),
        .sticky_clr_wr (sticky_clr_wr),
        .shadow_mode   (shadow_mode),
        .shadow_black  (shadow_black),
        .shadow_ratio  (shadow_ratio),
        .shadow_thresh (shadow_thresh),
        .height        (height)
`ifdef EXPOSURE_FUSION_CTRL_IRQ_EN
        ,
        .commit_pulse  (commit),
        .irq           (irq)
`endif
    );

    assign beat      = snoop_tvalid & snoop_tready;
    assign sof       = beat & snoop_tuser0;
    assign eol       = beat & snoop_tlast;
    // HEIGHT of 0 is treated as a one-line frame.
    assign last_line = (height == '0) ? '0 : height - HEIGHT_W'(1);

    assign r_vid_output_mode = active_mode;

    always_comb begin
        state_n   = state;
        line_n    = line_cnt;
        drain_n   = drain_cnt;
        commit    = 1'b0;
        fc_inc    = 1'b0;
        early_sof = 1'b0;
        case (state)
            ST_IDLE: begin
                commit = pending;
                if (go) state_n = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (sof) begin
                    state_n = ST_FRAME;
                    line_n  = '0;
                    fc_inc  = 1'b1;
                end
            end
            ST_FRAME: begin
                if (sof) begin
                    line_n    = '0;
                    fc_inc    = 1'b1;
                    early_sof = 1'b1;
                end else if (eol) begin
                    if (line_cnt == last_line) begin
                        state_n = ST_DRAIN;
                        drain_n = DRAIN_W'(DRAIN_CYCLES);
                    end else begin
                        line_n = line_cnt + HEIGHT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // A new frame aborts the drain; the commit slips to its end.
                if (sof) begin
                    state_n = ST_FRAME;
                    line_n  = '0;
                    drain_n = '0;
                    fc_inc  = 1'b1;
                end else if ((drain_cnt == '0) || (snoop_tready && (drain_cnt == DRAIN_W'(1)))) begin
                    state_n = ST_WAIT_SOF;
                    drain_n = '0;
                    commit  = pending;
                end else if (snoop_tready) begin
                    drain_n = drain_cnt - DRAIN_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Clearing GO (now or already) forces IDLE and abandons any frame.
        if (go_stop_wr || !go) begin
            state_n   = ST_IDLE;
            line_n    = '0;
            drain_n   = '0;
            fc_inc    = 1'b0;
            early_sof = 1'b0;
            if (state != ST_IDLE) commit = 1'b0;
        end
    end

    always_ff @(posedge main_clock or negedge main_reset_n) begin
        if (!main_reset_n) begin
            state                <= ST_IDLE;
            line_cnt             <= '0;
            drain_cnt            <= '0;
            frame_count          <= '0;
            pending              <= 1'b0;
            sticky               <= 1'b0;
            active_mode          <= MODE_FUSION;
            r_vid_black_level    <= '0;
            r_vid_exposure_ratio <= '0;
            r_vid_threshold      <= '0;
        end else begin
            state     <= state_n;
            line_cnt  <= line_n;
            drain_cnt <= drain_n;
            if (fc_inc) frame_count <= frame_count + 32'd1;
            if (early_sof) sticky <= 1'b1;
            else if (sticky_clr_wr) sticky <= 1'b0;
            // A COMMIT write landing on a commit cycle re-arms for the next boundary.
            if (commit_wr) pending <= 1'b1;
            else if (commit) pending <= 1'b0;
            if (commit) begin
                active_mode          <= output_mode_e'(shadow_mode);
                r_vid_black_level    <= shadow_black;
                r_vid_exposure_ratio <= shadow_ratio;
                r_vid_threshold      <= shadow_thresh;
            end
        end
    end

endmodule

// File: tb/tb_intel_vvp_exposure_fusion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intel_vvp_exposure_fusion_ctrl
// Randomized stimulus with a behavioural reference model; register reads are
// scored through a queue, active outputs are compared every cycle.
// -----------------------------------------------------------------------------
module tb_intel_vvp_exposure_fusion_ctrl;

    localparam int DRAIN = 13;
    localparam int P_IDLE = 0, P_WAIT = 1, P_FRAME = 2, P_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  address;
    logic        wr, rd;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdv;
    logic        tvalid, tready, tlast, tuser0;
    logic [1:0]  o_mode;
    logic [15:0] o_black;
    logic [16:0] o_ratio;
    logic [15:0] o_thresh;
`ifdef EXPOSURE_FUSION_CTRL_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    intel_vvp_exposure_fusion_ctrl #(.DRAIN_CYCLES(DRAIN), .ADDR_WIDTH(4)) dut (
        .main_clock          (clk),
        .main_reset_n        (rst_n),
        .av_mm_address       (address),
        .av_mm_write         (wr),
        .av_mm_read          (rd),
        .av_mm_writedata     (wdata),
        .av_mm_readdata      (rdata),
        .av_mm_readdatavalid (rdv),
        .snoop_tvalid        (tvalid),
        .snoop_tready        (tready),
        .snoop_tlast         (tlast),
        .snoop_tuser0        (tuser0),
        .r_vid_output_mode   (o_mode),
        .r_vid_black_level   (o_black),
        .r_vid_exposure_ratio(o_ratio),
        .r_vid_threshold     (o_thresh)
`ifdef EXPOSURE_FUSION_CTRL_IRQ_EN
        ,
        .irq                 (irq)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rd_q[$];

    // ---------------- reference model ----------------
    bit          m_go, m_pending, m_sticky;
    int          m_phase;       // 0 idle, 1 waiting for SOF, 2 in frame, 3 draining
    int          m_lines_seen;  // completed lines of the current frame
    int          m_drain_left;  // tready cycles still owed to the pipeline
    logic [31:0] m_fc;
    logic [31:0] sh [2:6];
    logic [31:0] act [2:5];

    function automatic logic [31:0] field_mask(int a);
        case (a)
            2: return 32'h3;
            4: return 32'h1FFFF;
            default: return 32'hFFFF;
        endcase
    endfunction

    function automatic logic [31:0] model_read(int a);
        logic [1:0] st;
        st = m_phase[1:0];
        case (a)
            0: return {31'd0, m_go};
            1: return {27'd0, m_sticky, st, m_pending, m_phase != P_IDLE};
            2, 3, 4, 5, 6: return sh[a];
            7: return m_fc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_go = 0; m_pending = 0; m_sticky = 0; m_phase = P_IDLE;
        m_lines_seen = 0; m_drain_left = 0; m_fc = 0;
        for (int i = 2; i <= 6; i++) sh[i] = 0;
        for (int i = 2; i <= 5; i++) act[i] = 0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        int  a, frame_lines, next_phase;
        bit  sof, eol, boundary, new_frame, early, stop, creq, sclr;
        if (!rst_n) begin
            model_reset();
        end else begin
            a = int'(address);
            if (rd) rd_q.push_back(model_read(a));
            sof = tvalid && tready && tuser0;
            eol = tvalid && tready && tlast;
            frame_lines = (sh[6] == 0) ? 1 : int'(sh[6]);
            boundary = 0; new_frame = 0; early = 0;
            next_phase = m_phase;
            if (m_phase == P_IDLE) begin
                boundary = 1;
                if (m_go) next_phase = P_WAIT;
            end else if (sof) begin
                new_frame = 1;
                early = (m_phase == P_FRAME);
                next_phase = P_FRAME;
                m_lines_seen = 0;
                m_drain_left = 0;
            end else if (m_phase == P_FRAME && eol) begin
                if (m_lines_seen + 1 == frame_lines) begin
                    next_phase = P_DRAIN;
                    m_drain_left = DRAIN;
                end else begin
                    m_lines_seen++;
                end
            end else if (m_phase == P_DRAIN) begin
                if (tready && m_drain_left > 0) m_drain_left--;
                if (m_drain_left == 0) begin
                    boundary = 1;
                    next_phase = P_WAIT;
                end
            end
            stop = (wr && a == 0 && !wdata[0]) || !m_go;
            if (stop) begin
                if (m_phase != P_IDLE) boundary = 0;
                new_frame = 0; early = 0;
                next_phase = P_IDLE;
                m_lines_seen = 0;
                m_drain_left = 0;
            end
            if (boundary && m_pending)
                for (int i = 2; i <= 5; i++) act[i] = sh[i];
            creq = wr && a == 0 && wdata[1];
            sclr = wr && a == 1 && wdata[4];
            if (creq) m_pending = 1;
            else if (boundary) m_pending = 0;
            if (early) m_sticky = 1;
            else if (sclr) m_sticky = 0;
            if (new_frame) m_fc = m_fc + 1;
            if (wr && a == 0) m_go = wdata[0];
            if (wr && a >= 2 && a <= 6) sh[a] = wdata & field_mask(a);
            m_phase = next_phase;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [31:0] exp;
        logic [50:0] got_o, exp_o;
        got_o = {o_mode, o_black, o_ratio, o_thresh};
        exp_o = {act[2][1:0], act[3][15:0], act[4][16:0], act[5][15:0]};
        if (!rst_n) begin
            vectors++;
            if ({rdv, rdata, got_o} !== 84'd0) begin
                miscompares++;
                $display("FAIL reset_state: got rdv=%0b rdata=%h outs=%h, want all 0", rdv, rdata, got_o);
            end
        end else begin
            if (rdv) begin
                vectors++;
                if (rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_spurious: readdatavalid=1 with data %h, want no response", rdata);
                end else begin
                    exp = rd_q.pop_front();
                    if (rdata !== exp) begin
                        miscompares++;
                        $display("FAIL readdata: got %h, want %h", rdata, exp);
                    end
                end
            end else if (rd_q.size() != 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_missing: readdatavalid=0, want 1 with data %h", rd_q[0]);
                rd_q.delete();
            end
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL active_outputs: got mode=%h black=%h ratio=%h thr=%h, want mode=%h black=%h ratio=%h thr=%h",
                         o_mode, o_black, o_ratio, o_thresh, exp_o[50:49], exp_o[48:33], exp_o[32:16], exp_o[15:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(bit tv, bit tr, bit tl, bit tu, bit w, bit r, int a, logic [31:0] d);
        tvalid = tv; tready = tr; tlast = tl; tuser0 = tu;
        wr = w; rd = r; address = a[3:0]; wdata = d;
        @(negedge clk);
    endtask

    task automatic idle(int n, bit stall = 0);
        for (int i = 0; i < n; i++)
            drive(0, stall ? 1'b0 : ($urandom_range(0, 3) != 0), 0, 0, 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 8), 0);
    endtask

    task automatic wreg(int a, logic [31:0] d);
        drive(0, $urandom_range(0, 1), 0, 0, 1, 0, a, d);
    endtask

    task automatic rreg(int a);
        drive(0, 1, 0, 0, 0, 1, a, 0);
    endtask

    task automatic beat(bit tl, bit tu);
        bit tr;
        if ($urandom_range(0, 4) == 0) idle(1);
        do begin
            tr = $urandom_range(0, 3) != 0;
            drive(1, tr, tl, tu, 0, $urandom_range(0, 7) == 0, $urandom_range(0, 8), 0);
        end while (!tr);
    endtask

    task automatic send_line(bit sof, int len);
        for (int i = 0; i < len; i++) beat(i == len - 1, sof && i == 0);
    endtask

    task automatic send_frame(int h);
        for (int l = 0; l < h; l++) send_line(l == 0, $urandom_range(2, 3));
    endtask

    task automatic wait_phase(int p, string tag);
        int guard = 0;
        while (m_phase != p) begin
            idle(1);
            if (++guard > 400) begin
                vectors++; miscompares++;
                $display("FAIL %s: timeout, phase %0d, want %0d", tag, m_phase, p);
                break;
            end
        end
    endtask

    initial begin
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // reset readback
        for (int a = 0; a <= 7; a++) rreg(a);
`ifndef EXPOSURE_FUSION_CTRL_IRQ_EN
        rreg(8);
`endif
        rreg(12);

        // idle commit, shadow readback before commit
        wreg(4, 32'h4000);
        rreg(4);
        wreg(0, 32'h2);
        idle(3);
        rreg(1);
        for (int a = 2; a <= 6; a++) begin
            wreg(a, $urandom);
            rreg(a);
        end
        wreg(15, 32'hFFFF_FFFF);
        rreg(15);

        // mid-frame commit applied after drain
        wreg(6, 4);
        wreg(0, 1);
        idle(2);
        send_line(1, 3);
        send_line(0, 2);
        wreg(4, 32'h8000);
        wreg(0, 32'h3);
        send_line(0, 3);
        send_line(0, 2);
        wait_phase(P_WAIT, "drain_commit");
        rreg(7); rreg(1);

        // SOF aborts drain at count 5
        wreg(4, $urandom);
        wreg(0, 32'h3);
        send_frame(4);
        begin
            int guard = 0;
            while (!(m_phase == P_DRAIN && m_drain_left == 5) && guard < 100) begin
                drive(0, 1, 0, 0, 0, 0, 0, 0);
                guard++;
            end
        end
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        rreg(1);
        for (int l = 1; l < 4; l++) send_line(0, 2);
        wait_phase(P_WAIT, "abort_commit");
        rreg(7); rreg(1);

        // early SOF sets sticky and restarts the line count
        send_line(1, 2);
        send_line(0, 2);
        send_line(1, 2);
        rreg(1); rreg(7);
        for (int l = 1; l < 4; l++) send_line(0, 3);
        wreg(1, 32'h10);
        rreg(1);

        // tready stall during drain
        wreg(5, $urandom);
        wreg(0, 32'h3);
        wait_phase(P_WAIT, "pre_stall");
        send_frame(4);
        idle(20, 1);
        rreg(1);
        wait_phase(P_WAIT, "stall_commit");

        // GO cleared mid-frame
        send_line(1, 2);
        wreg(0, 32'h2);
        rreg(1);
        idle(3);
        wreg(0, 32'h1);

        // random traffic
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 8))
                0:       wreg($urandom_range(2, 5), $urandom);
                1:       wreg(0, 32'h3);
                2:       wreg(0, ($urandom_range(0, 3) == 0) ? 32'h0 : {30'd0, 1'($urandom_range(0, 1)), 1'b1});
                3:       send_line(1, $urandom_range(2, 3));
                4, 5:    send_line(0, $urandom_range(2, 3));
                6:       idle($urandom_range(1, 15), $urandom_range(0, 3) == 0);
                7:       wreg(6, $urandom_range(0, 3));
                default: rreg($urandom_range(0, 8));
            endcase
        end
        for (int a = 0; a <= 7; a++) rreg(a);
        idle(5);
        if (rd_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL rd_leftover: %0d responses outstanding, want 0", rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intel_vvp_exposure_fusion_ctrl.md
INTEL_VVP_EXPOSURE_FUSION_CTRL -- requirements
Module: intel_vvp_exposure_fusion_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 13: number of tready-high cycles the fusion pipeline needs to flush after a frame's last beat.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: width of the register word address.
REQ-003 main_clock  in  1  sole clock. One clock; reset is asynchronous and active-low.
REQ-004 main_reset_n  in  1  asynchronous, active-low reset.
REQ-005 av_mm_address  in  ADDR_WIDTH  register word address.
REQ-006 av_mm_write / av_mm_read  in  1 each  single-cycle access strobes.
REQ-007 av_mm_writedata  in  32  write data.
REQ-008 av_mm_readdata  out  32  read data, valid with av_mm_readdatavalid.
REQ-009 av_mm_readdatavalid  out  1  pulses 1 cycle after av_mm_read.
REQ-010 snoop_tvalid / snoop_tready / snoop_tlast / snoop_tuser0  in  1 each  observed fusion input-stream handshake, end of line, start of frame.
REQ-011 r_vid_output_mode  out  2  active mode (00 fusion, 01 short, 10 reserved, 11 long).
REQ-012 r_vid_black_level  out  16 / r_vid_exposure_ratio  out  17 / r_vid_threshold  out  16  active fusion settings.

Function
REQ-013 Register map, word addresses: 0 CTRL (b0 GO rw, b1 COMMIT write-1 sets pending), 1 STATUS ro (b0 running, b1 pending, b3:2 state, b4 early-SOF sticky, write-1 clears b4), 2 MODE, 3 BLACK, 4 RATIO, 5 THRESH, 6 HEIGHT[15:0], 7 FRAME_COUNT[31:0] ro; unmapped reads return 0 and writes are ignored.
REQ-014 Writes to addresses 2-5 SHALL update only shadow registers; active outputs change only on commit.
REQ-015 Beat = snoop_tvalid & snoop_tready; SOF = beat & snoop_tuser0; EOL = beat & snoop_tlast.
REQ-016 FSM states IDLE(0), WAIT_SOF(1), FRAME(2), DRAIN(3).
REQ-017 IDLE: GO=1 -> WAIT_SOF; a pending commit SHALL apply on the next cycle.
REQ-018 WAIT_SOF: on SOF -> FRAME, line counter = 0, FRAME_COUNT += 1.
REQ-019 FRAME: on each EOL, line counter += 1; on the EOL where the counter equals max(HEIGHT,1)-1 -> DRAIN, load the drain counter with DRAIN_CYCLES.
REQ-020 FRAME: SOF before frame end SHALL restart the line counter, increment FRAME_COUNT, and set the early-SOF sticky bit; the state stays FRAME.
REQ-021 DRAIN: the counter decrements only on cycles with snoop_tready=1; at 0, apply any pending commit, clear pending, and go to WAIT_SOF.
REQ-022 DRAIN: an SOF SHALL abort the drain without committing (pending kept), go to FRAME, and increment FRAME_COUNT; the commit moves to the end of that frame.
REQ-023 Commit SHALL copy all four shadows to the outputs in one cycle, so the outputs never mix old and new values.
REQ-024 GO written 0 in any state -> IDLE the next cycle; the line and drain counters clear.
REQ-025 A COMMIT write coinciding with a commit cycle SHALL leave pending set, to apply at the next boundary.
REQ-026 Readback of the shadow registers SHALL return the shadow value, not the active value.

Reset
REQ-027 On main_reset_n=0: state IDLE, all shadow and active registers 0, pending 0, FRAME_COUNT 0, sticky 0, av_mm_readdata 0, av_mm_readdatavalid 0.

Configuration
REQ-028 Macro EXPOSURE_FUSION_CTRL_IRQ_EN defined: add output irq (1 bit, level) and register 8 IRQ (b0 enable rw, b1 commit-done status, write-1 clears).
REQ-029 With EXPOSURE_FUSION_CTRL_IRQ_EN, irq = enable & status, and status is set on every commit.
REQ-030 Without EXPOSURE_FUSION_CTRL_IRQ_EN: no irq port, and address 8 reads 0.

Structure
REQ-031 Package intel_vvp_exposure_fusion_pkg SHALL hold the register address constants, the FSM state enum, the output-mode enum, and the width constants (2/16/17).
REQ-032 Sub-module intel_vvp_exposure_fusion_ctrl_regs SHALL hold the register file with shadow storage and read mux; the FSM and commit logic stay at top level.

Verification
REQ-033 Reset, then read addresses 0-7 -> all 0; outputs 0.
REQ-034 GO=0, write RATIO=0x4000, COMMIT -> r_vid_exposure_ratio=0x4000 two cycles after the write; pending=0.
REQ-035 GO=1, HEIGHT=4, RATIO=0x8000+COMMIT mid-frame -> output unchanged until 13 tready cycles after the 4th EOL, then 0x8000; FRAME_COUNT=1.
REQ-036 Same as REQ-035 but SOF injected at drain count 5 -> no commit; commit after next frame's drain; FRAME_COUNT=2.
REQ-037 HEIGHT=4, SOF after 2 EOLs -> STATUS b4=1, FRAME_COUNT=2, line counter restarts.
REQ-038 snoop_tready held 0 for 20 cycles during DRAIN -> drain counter frozen, no commit until tready returns.
